// File: rtl/io_bus_resp_if.sv
// CPU-side IO bus: word address, store data, store strobe and load data.
interface io_bus_resp_if;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic [31:0] io_din;

  // CPU drives address/data/strobe and consumes load data.
  modport master (
    output io_addr,
    output io_dout,
    output io_we,
    input  io_din
  );

  // Responder decodes address/data/strobe and returns load data.
  modport slave (
    input  io_addr,
    input  io_dout,
    input  io_we,
    output io_din
  );
endinterface

// File: rtl/io_bus_resp.sv
// Memory-mapped IO responder: LED and 7-seg output registers, switch
// capture on a debounced "input ready" button, a display handshake cleared
// by a debounced "display consumed" button, and a free-running cycle counter.
module io_bus_resp #(
  parameter int DBNC_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  io_bus_resp_if.slave  bus,
  input  logic [15:0]   sw,
  input  logic          btn_in,
  input  logic          btn_out,
  output logic [15:0]   led,
  output logic [31:0]   seg_data,
  output logic          seg_vld
);

  localparam int             CNT_W    = $clog2(DBNC_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBNC_CYCLES - 1);

  localparam logic [7:0] ADDR_LED   = 8'h00;
  localparam logic [7:0] ADDR_INVLD = 8'h04;
  localparam logic [7:0] ADDR_INDAT = 8'h08;
  localparam logic [7:0] ADDR_SEGRD = 8'h0C;
  localparam logic [7:0] ADDR_SEG   = 8'h10;
  localparam logic [7:0] ADDR_CYC   = 8'h14;

  // Synchronizer stages
  logic [15:0] sw_s1_q, sw_s2_q;
  logic        bin_s1_q, bin_s2_q;
  logic        bout_s1_q, bout_s2_q;

  // Debounce state
  logic             bin_acc_q, bin_acc_d;
  logic [CNT_W-1:0] bin_cnt_q, bin_cnt_d;
  logic             bin_rise;
  logic             bout_acc_q, bout_acc_d;
  logic [CNT_W-1:0] bout_cnt_q, bout_cnt_d;
  logic             bout_rise;

  // Architectural registers
  logic [15:0] led_q, led_d;
  logic [31:0] seg_data_q, seg_data_d;
  logic        seg_vld_q, seg_vld_d;
  logic        in_vld_q, in_vld_d;
  logic [15:0] in_data_q, in_data_d;
  logic [31:0] cyc_cnt_q, cyc_cnt_d;

  // Store decode
  logic wr_led, wr_invld, wr_seg;

  assign wr_led   = bus.io_we && (bus.io_addr == ADDR_LED);
  assign wr_invld = bus.io_we && (bus.io_addr == ADDR_INVLD);
  assign wr_seg   = bus.io_we && (bus.io_addr == ADDR_SEG);

  // Two-flop synchronizers; reset so a held button must re-qualify after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      bin_s1_q  <= 1'b0;
      bin_s2_q  <= 1'b0;
      bout_s1_q <= 1'b0;
      bout_s2_q <= 1'b0;
    end else begin
      sw_s1_q   <= sw;
      sw_s2_q   <= sw_s1_q;
      bin_s1_q  <= btn_in;
      bin_s2_q  <= bin_s1_q;
      bout_s1_q <= btn_out;
      bout_s2_q <= bout_s1_q;
    end
  end

  // btn_in debounce: flip on the DBNC_CYCLES-th consecutive differing cycle,
  // and flag the rise on that same edge so the capture is not delayed.
  always_comb begin
    bin_acc_d = bin_acc_q;
    bin_cnt_d = '0;
    bin_rise  = 1'b0;
    if (bin_s2_q != bin_acc_q) begin
      if (bin_cnt_q == CNT_LAST) begin
        bin_acc_d = bin_s2_q;
        bin_rise  = bin_s2_q;
      end else begin
        bin_cnt_d = bin_cnt_q + CNT_W'(1);
      end
    end
  end

  // btn_out debounce, same scheme as btn_in.
  always_comb begin
    bout_acc_d = bout_acc_q;
    bout_cnt_d = '0;
    bout_rise  = 1'b0;
    if (bout_s2_q != bout_acc_q) begin
      if (bout_cnt_q == CNT_LAST) begin
        bout_acc_d = bout_s2_q;
        bout_rise  = bout_s2_q;
      end else begin
        bout_cnt_d = bout_cnt_q + CNT_W'(1);
      end
    end
  end

  // Next state of the architectural registers from stores and button events.
  always_comb begin
    led_d      = led_q;
    seg_data_d = seg_data_q;
    seg_vld_d  = seg_vld_q;
    in_vld_d   = in_vld_q;
    in_data_d  = in_data_q;
    cyc_cnt_d  = cyc_cnt_q + 32'd1;

    if (wr_led) begin
      led_d = bus.io_dout[15:0];
    end

    // A press only captures into an empty slot; a clear of a full slot
    // always wins over a simultaneous press.
    if (bin_rise && !in_vld_q) begin
      in_vld_d  = 1'b1;
      in_data_d = sw_s2_q;
    end else if (wr_invld) begin
      in_vld_d = 1'b0;
    end

    // The store is judged against the pre-edge seg_vld: a full display
    // drops it (and an ack empties it), an empty one takes it.
    if (wr_seg && !seg_vld_q) begin
      seg_data_d = bus.io_dout;
      seg_vld_d  = 1'b1;
    end else if (bout_rise) begin
      seg_vld_d = 1'b0;
    end
  end

  // State registers, all returned to their idle values by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_acc_q  <= 1'b0;
      bin_cnt_q  <= '0;
      bout_acc_q <= 1'b0;
      bout_cnt_q <= '0;
      led_q      <= '0;
      seg_data_q <= '0;
      seg_vld_q  <= 1'b0;
      in_vld_q   <= 1'b0;
      in_data_q  <= '0;
      cyc_cnt_q  <= '0;
    end else begin
      bin_acc_q  <= bin_acc_d;
      bin_cnt_q  <= bin_cnt_d;
      bout_acc_q <= bout_acc_d;
      bout_cnt_q <= bout_cnt_d;
      led_q      <= led_d;
      seg_data_q <= seg_data_d;
      seg_vld_q  <= seg_vld_d;
      in_vld_q   <= in_vld_d;
      in_data_q  <= in_data_d;
      cyc_cnt_q  <= cyc_cnt_d;
    end
  end

  // Load data mux; purely combinational, no read side effects.
  always_comb begin
    bus.io_din = 32'b0;
    case (bus.io_addr)
      ADDR_LED:   bus.io_din = {16'b0, led_q};
      ADDR_INVLD: bus.io_din = {31'b0, in_vld_q};
      ADDR_INDAT: bus.io_din = {16'b0, in_data_q};
      ADDR_SEGRD: bus.io_din = {31'b0, ~seg_vld_q};
      ADDR_SEG:   bus.io_din = seg_data_q;
      ADDR_CYC:   bus.io_din = cyc_cnt_q;
      default:    bus.io_din = 32'b0;
    endcase
  end

  assign led      = led_q;
  assign seg_data = seg_data_q;
  assign seg_vld  = seg_vld_q;

endmodule
